// File: rtl/commit_trace_pkg.sv
// Shared types and width helpers for the commit trace serializer.
package commit_trace_pkg;

  localparam int unsigned EntryXlen = 64;

  typedef enum logic {
    COMMIT = 1'b0,
    TRAP   = 1'b1
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e            kind;
    logic [EntryXlen-1:0]   pc;
    logic [31:0]            insn;
    logic                   wen;
    logic [4:0]             waddr;
    logic [EntryXlen-1:0]   wdata;
  } trace_entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned push_cnt_width(input int unsigned max_push);
    return $clog2(max_push + 1);
  endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Multi-push, single-pop ring buffer of trace entries; surplus pushes are
// trimmed from the tail of the push order.
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_PUSH = 3,
  localparam int unsigned PW = ptr_width(DEPTH),
  localparam int unsigned CW = count_width(DEPTH),
  localparam int unsigned NW = push_cnt_width(MAX_PUSH)
) (
  input  logic          clock,
  input  logic          reset,
  input  trace_entry_t  push_data [MAX_PUSH],
  input  logic [NW-1:0] push_n,
  input  logic          pop,
  output trace_entry_t  head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic [NW-1:0] accepted
);

  trace_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] room;

  // A same-cycle pop frees its slot for this cycle's pushes.
  always_comb begin
    room = CW'(DEPTH) - count_q + CW'(pop);
    if (CW'(push_n) <= room) begin
      accepted = push_n;
    end else begin
      accepted = NW'(room);
    end
    count_next = count_q + CW'(accepted) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MAX_PUSH); i++) begin
        if (i < int'(accepted)) begin
          mem[wptr_q + PW'(i)] <= push_data[i];
        end
      end
      wptr_q  <= wptr_q + PW'(accepted);
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_next;
    end
  end

  assign head  = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/commit_trace_serializer.sv
// Compacts per-cycle retire lanes plus an optional trap into program order and
// streams them one per cycle to the difftest checker.
module commit_trace_serializer
  import commit_trace_pkg::*;
#(
  parameter int unsigned COMMITS = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned XLEN    = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [COMMITS-1:0]      in_valid,
  input  logic [COMMITS*XLEN-1:0] in_pc,
  input  logic [COMMITS*32-1:0]   in_insn,
  input  logic [COMMITS-1:0]      in_wen,
  input  logic [COMMITS*5-1:0]    in_waddr,
  input  logic [COMMITS*XLEN-1:0] in_wdata,
  input  logic                    trap_valid,
  input  logic [XLEN-1:0]         trap_pc,
  input  logic [XLEN-1:0]         trap_cause,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_kind,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_insn,
  output logic                    out_wen,
  output logic [4:0]              out_waddr,
  output logic [XLEN-1:0]         out_wdata,
  output logic                    stall,
  output logic                    overflow
);

  localparam int unsigned MaxPush = COMMITS + 1;
  localparam int unsigned NW      = push_cnt_width(MaxPush);
  localparam int unsigned CW      = count_width(DEPTH);

  trace_entry_t  push_data [MaxPush];
  trace_entry_t  head;
  logic [NW-1:0] push_n, accepted;
  logic [CW-1:0] count, count_next;
  logic          pop;
  logic          stall_q, overflow_q;

  // Prefix compaction: each valid lane lands at the number of valid lanes
  // below it; the trap always lands last.
  always_comb begin
    trace_entry_t e;
    push_n = '0;
    e      = '0;
    for (int i = 0; i < int'(MaxPush); i++) begin
      push_data[i] = '0;
    end
    for (int i = 0; i < int'(COMMITS); i++) begin
      if (in_valid[i]) begin
        e.kind  = COMMIT;
        e.pc    = in_pc[i*XLEN +: XLEN];
        e.insn  = in_insn[i*32 +: 32];
        e.wen   = in_wen[i];
        e.waddr = in_wen[i] ? in_waddr[i*5 +: 5] : 5'd0;
        e.wdata = in_wen[i] ? in_wdata[i*XLEN +: XLEN] : '0;
        push_data[push_n] = e;
        push_n = push_n + 1'b1;
      end
    end
    if (trap_valid) begin
      e.kind  = TRAP;
      e.pc    = trap_pc;
      e.insn  = '0;
      e.wen   = 1'b0;
      e.waddr = '0;
      e.wdata = trap_cause;
      push_data[push_n] = e;
      push_n = push_n + 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  commit_trace_fifo #(
    .DEPTH    (DEPTH),
    .MAX_PUSH (MaxPush)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_data  (push_data),
    .push_n     (push_n),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .count_next (count_next),
    .accepted   (accepted)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stall_q    <= (CW'(DEPTH) - count_next) < CW'(MaxPush);
      overflow_q <= overflow_q | (accepted != push_n);
    end
  end

  assign stall     = stall_q;
  assign overflow  = overflow_q;
  assign out_kind  = head.kind;
  assign out_pc    = head.pc;
  assign out_insn  = head.insn;
  assign out_wen   = head.wen;
  assign out_waddr = head.waddr;
  assign out_wdata = head.wdata;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Bench for commit_trace_serializer: queue-based reference model, per-cycle
// compare, and literal checks on the directed scenarios.
module tb_commit_trace_serializer;

  localparam int COMMITS = 2;
  localparam int DEPTH   = 8;
  localparam int XLEN    = 64;

  logic                    clock;
  logic                    reset;
  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS*5-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_pc;
  logic [XLEN-1:0]         trap_cause;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_kind;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic                    stall;
  logic                    overflow;

  commit_trace_serializer #(
    .COMMITS (COMMITS),
    .DEPTH   (DEPTH),
    .XLEN    (XLEN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_insn    (in_insn),
    .in_wen     (in_wen),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_pc     (out_pc),
    .out_insn   (out_insn),
    .out_wen    (out_wen),
    .out_waddr  (out_waddr),
    .out_wdata  (out_wdata),
    .stall      (stall),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          kind;
    logic [63:0] pc;
    logic [31:0] insn;
    bit          wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;
  ent_t mq[$];
  ent_t pend[$];
  ent_t obs[$];
  bit   m_ovf, m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue updated once per rising edge.
  always @(posedge clock) begin
    ent_t e;
    int   room;
    bit   pop;
    if (reset && out_valid && out_ready) begin
      e.kind = out_kind; e.pc = out_pc; e.insn = out_insn;
      e.wen = out_wen; e.waddr = out_waddr; e.wdata = out_wdata;
      obs.push_back(e);
    end
    if (!reset) begin
      mq.delete();
      m_ovf   = 0;
      m_stall = 0;
    end else begin
      pend.delete();
      for (int i = 0; i < COMMITS; i++) begin
        if (in_valid[i]) begin
          e.kind  = 0;
          e.pc    = in_pc[i*XLEN +: XLEN];
          e.insn  = in_insn[i*32 +: 32];
          e.wen   = in_wen[i];
          e.waddr = in_wen[i] ? in_waddr[i*5 +: 5] : 5'd0;
          e.wdata = in_wen[i] ? in_wdata[i*XLEN +: XLEN] : 64'd0;
          pend.push_back(e);
        end
      end
      if (trap_valid) begin
        e.kind = 1; e.pc = trap_pc; e.insn = 0; e.wen = 0; e.waddr = 0; e.wdata = trap_cause;
        pend.push_back(e);
      end
      pop  = (mq.size() != 0) && out_ready;
      room = DEPTH - mq.size() + int'(pop);
      if (pop) void'(mq.pop_front());
      for (int i = 0; i < pend.size(); i++) begin
        if (i < room) mq.push_back(pend[i]);
        else m_ovf = 1;
      end
      m_stall = (DEPTH - mq.size()) < (COMMITS + 1);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("out_valid", out_valid, mq.size() != 0);
      check("stall", stall, m_stall);
      check("overflow", overflow, m_ovf);
      if (mq.size() != 0) begin
        check("out_kind", out_kind, mq[0].kind);
        check("out_pc", out_pc, mq[0].pc);
        check("out_insn", out_insn, mq[0].insn);
        check("out_wen", out_wen, mq[0].wen);
        check("out_waddr", out_waddr, mq[0].waddr);
        check("out_wdata", out_wdata, mq[0].wdata);
      end
    end
  end

  task automatic clear_inputs();
    in_valid = '0; in_pc = '0; in_insn = '0; in_wen = '0; in_waddr = '0; in_wdata = '0;
    trap_valid = 0; trap_pc = '0; trap_cause = '0;
  endtask

  task automatic set_lane(input int i, input bit v, input logic [63:0] pc, input logic [31:0] insn,
                          input bit wen, input logic [4:0] wa, input logic [63:0] wd);
    in_valid[i]            = v;
    in_pc[i*XLEN +: XLEN]    = pc;
    in_insn[i*32 +: 32]      = insn;
    in_wen[i]              = wen;
    in_waddr[i*5 +: 5]       = wa;
    in_wdata[i*XLEN +: XLEN] = wd;
  endtask

  initial begin
    int k;
    clear_inputs();
    out_ready = 0;
    reset     = 0;
    repeat (3) @(negedge clock);
    reset  = 1;
    chk_en = 1;
    @(negedge clock);

    // Idle after reset: everything zero.
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_wdata", out_wdata, 0);
    check("rst_out_misc", {out_kind, out_wen, out_waddr, out_insn}, 0);

    // Dual retire plus trap.
    obs.delete();
    out_ready = 1;
    set_lane(0, 1, 64'h8000_0000, 32'h0000_0013, 1, 5'd1, 64'h11);
    set_lane(1, 1, 64'h8000_0004, 32'h0000_0093, 0, 5'd2, 64'h22);
    trap_valid = 1; trap_pc = 64'h8000_0008; trap_cause = 64'h2;
    @(negedge clock);
    clear_inputs();
    repeat (5) @(negedge clock);
    check("dual_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("dual_pc0", obs[0].pc, 64'h8000_0000);
      check("dual_pc1", obs[1].pc, 64'h8000_0004);
      check("dual_wdata1", obs[1].wdata, 0);
      check("dual_trap_kind", obs[2].kind, 1);
      check("dual_trap_wdata", obs[2].wdata, 64'h2);
      check("dual_trap_insn", obs[2].insn, 0);
    end

    // Lane compaction: only lane 1 valid.
    obs.delete();
    set_lane(0, 0, 64'h1111_1111, 32'hFFFF_FFFF, 1, 5'd7, 64'hBAD);
    set_lane(1, 1, 64'h8000_0010, 32'h0000_0033, 1, 5'd5, 64'hDEAD);
    @(negedge clock);
    clear_inputs();
    repeat (4) @(negedge clock);
    check("cmp_count", obs.size(), 1);
    if (obs.size() == 1) begin
      check("cmp_pc", obs[0].pc, 64'h8000_0010);
      check("cmp_waddr", obs[0].waddr, 5);
      check("cmp_wdata", obs[0].wdata, 64'hDEAD);
    end

    // Back-pressure: stall once count reaches 6, head holds, then drain.
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1, 64'h2000 + 64'(8 * c), 32'h13, 0, 0, 0);
      set_lane(1, 1, 64'h2004 + 64'(8 * c), 32'h13, 0, 0, 0);
      @(negedge clock);
      check($sformatf("bp_stall%0d", c), stall, c == 2);
    end
    clear_inputs();
    check("bp_head", out_pc, 64'h2000);
    repeat (3) @(negedge clock);
    check("bp_head_hold", out_pc, 64'h2000);
    out_ready = 1;
    @(negedge clock);
    check("bp_release", stall, 0);
    repeat (8) @(negedge clock);

    // Overflow: count 7, then push 2 with no room for lane 1.
    obs.delete();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1, 64'h3000 + 64'(8 * c), 0, 0, 0, 0);
      set_lane(1, 1, 64'h3004 + 64'(8 * c), 0, 0, 0, 0);
      @(negedge clock);
    end
    clear_inputs();
    set_lane(0, 1, 64'h3100, 0, 0, 0, 0);
    @(negedge clock);
    set_lane(0, 1, 64'hA0, 0, 0, 0, 0);
    set_lane(1, 1, 64'hB0, 0, 0, 0, 0);
    @(negedge clock);
    clear_inputs();
    check("ovf_set", overflow, 1);
    check("ovf_model_count", mq.size(), 8);
    check("ovf_stall", stall, 1);
    out_ready = 1;
    repeat (12) @(negedge clock);
    check("ovf_drained", obs.size(), 8);
    if (obs.size() == 8) check("ovf_last_pc", obs[7].pc, 64'hA0);
    check("ovf_sticky", overflow, 1);
    reset = 0;
    @(negedge clock);
    check("ovf_reset", overflow, 0);
    reset = 1;
    @(negedge clock);

    // Wrap with toggling ready; core respects stall.
    obs.delete();
    k = 0;
    for (int c = 0; c < 200 && obs.size() < 20; c++) begin
      out_ready = (c % 2) == 0;
      if (k < 20 && !stall) begin
        set_lane(0, 1, 64'h1000 + 64'(4 * k), 32'(k), 1, 5'(k), 64'(k));
        k++;
      end else begin
        clear_inputs();
      end
      @(negedge clock);
    end
    clear_inputs();
    check("wrap_count", obs.size(), 20);
    for (int i = 0; i < 20 && i < obs.size(); i++) begin
      check($sformatf("wrap_pc%0d", i), obs[i].pc, 64'h1000 + 64'(4 * i));
    end
    check("wrap_no_ovf", overflow, 0);

    // Random traffic, occasionally ignoring stall, with a mid-run reset.
    for (int c = 0; c < 400; c++) begin
      reset     = (c != 200);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < COMMITS; i++) begin
        set_lane(i, $urandom_range(0, 1), {$urandom, $urandom}, $urandom, $urandom_range(0, 1),
                 5'($urandom), {$urandom, $urandom});
      end
      trap_valid = ($urandom_range(0, 3) == 0);
      trap_pc    = {$urandom, $urandom};
      trap_cause = 64'($urandom_range(0, 15));
      if (stall && $urandom_range(0, 19) != 0) begin
        in_valid   = '0;
        trap_valid = 0;
      end
      @(negedge clock);
    end
    clear_inputs();
    reset     = 1;
    out_ready = 1;
    repeat (12) @(negedge clock);
    check("final_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_trace_serializer.md
# commit_trace_serializer

Sits directly upstream of the difftest checker: captures up to COMMITS retirement records plus one trap record per cycle from the core's retire stage and buffers them in a ring buffer. It presents them one per cycle, in program order, on a valid/ready port that the checker consumes. Back-pressure tells the core to hold retirement before the buffer can overflow; a sticky error flags any overflow that happens anyway.

## Interface
- COMMITS, 2, retire lanes per cycle (1..4)
- DEPTH, 8, buffer entries; power of two, ≥ 2·(COMMITS+1)
- XLEN, 64, PC/data width

- clock  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  COMMITS  lane i retired an instruction this cycle
- in_pc  in  COMMITS·XLEN  lane i PC, lane 0 in LSBs
- in_insn  in  COMMITS·32  lane i instruction bits
- in_wen  in  COMMITS  lane i wrote an integer register
- in_waddr  in  COMMITS·5  lane i destination register
- in_wdata  in  COMMITS·XLEN  lane i write data
- trap_valid  in  1  trap taken this cycle, after all valid lanes
- trap_pc  in  XLEN  trapping PC
- trap_cause  in  XLEN  mcause/scause value
- out_valid  out  1  head entry available
- out_ready  in  1  checker accepts head
- out_kind  out  1  0 = commit, 1 = trap
- out_pc  out  XLEN  entry PC
- out_insn  out  32  instruction (0 for trap)
- out_wen  out  1  register write (0 for trap)
- out_waddr  out  5  destination (0 for trap)
- out_wdata  out  XLEN  write data, or trap cause for traps
- stall  out  1  free entries < COMMITS+1; core must not retire
- overflow  out  1  sticky: an entry was dropped

## Operation
- Per-cycle push count n = popcount(in_valid) + trap_valid, range 0..COMMITS+1.
- Push order: valid lanes by ascending index, gaps compacted, then trap. Example: in_valid=2'b10 with trap_valid gives lane 1 at wptr and trap at wptr+1.
- Pop happens when out_valid && out_ready. Next count = count + accepted pushes − pop. A pop and pushes in the same cycle are both honoured; pushes may use the slot freed by that pop.
- Accepted pushes = min(n, DEPTH − count + pop). Excess records, taken from the tail of the push order, are discarded, and overflow is set.
- overflow stays at 1 until reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Out fields for trap entries: insn=0, wen=0, waddr=0, wdata=trap_cause.
- in_wdata and in_waddr of a lane are stored only when in_wen=1; otherwise they are stored as 0.

## Timing
- Reset (reset=0 at an edge): wptr=rptr=count=0, out_valid=0, stall=0, overflow=0. All out_* data fields are 0.
- Reset asserted mid-operation discards all buffered entries at that edge.
- Push-to-output latency is 1 cycle: a record pushed at edge k is visible on out_* after edge k when the buffer was empty.
- out_* data are driven from the head storage entry. They are stable while out_valid && !out_ready.
- Throughput: 1 pop per cycle sustained.
- stall is a registered output derived from the post-update count. It asserts the cycle after the count crosses the threshold.
- The DEPTH ≥ 2·(COMMITS+1) rule absorbs the one cycle of stall latency.
- out_valid = (count != 0), registered.

## Structure
- Package commit_trace_pkg holds:
  - enum trace_kind_e {COMMIT, TRAP}
  - packed struct trace_entry_t {kind, pc, insn, wen, waddr, wdata}
  - localparam helpers for pointer and count widths
- Sub-module commit_trace_fifo: a multi-push (up to COMMITS+1), single-pop ring buffer of trace_entry_t. It reports accepted-push count and count.
- The top level performs lane compaction (prefix popcount) and computes stall and overflow.

## Test plan
- Reset, idle: after reset is released with all inputs 0 → out_valid=0, stall=0, overflow=0, all out_* = 0.
- Dual retire plus trap:
  - Stimulus: in_valid=2'b11 with PCs 0x80000000 and 0x80000004; trap_valid with cause 0x2; out_ready=1.
  - Required response: three consecutive out beats in order: PC 0x80000000, then PC 0x80000004, then a trap entry with wdata=0x2.
- Lane compaction: in_valid=2'b10, lane 1 PC 0x80000010, wen=1, waddr=5, wdata=0xDEAD → a single entry with those values; lane 0 data is absent.
- Back-pressure:
  - Stimulus: out_ready=0, push 2 per cycle.
  - Required response: stall rises after count reaches 6 (DEPTH=8, COMMITS=2); out_pc holds stable.
  - Then raise out_ready=1: entries drain in order, and stall falls once count ≤ 5.
- Overflow: with count=7 and out_ready=0, push 2 → only lane 0 is stored, count=8, overflow=1. overflow stays 1 after the buffer drains and clears only on reset.
- Wrap and simultaneous push/pop: stream 20 commits with out_ready toggling 1,0,1,… → all 20 PCs emerge in order across pointer wrap, with no loss and overflow=0.
